// File: rtl/uart_rx_param.sv
// Oversampling UART receiver with a one-entry holding register.
// Reception runs at 16 ticks per bit. Data, parity and framing status are
// held until the consumer acknowledges with rd. A frame that completes while
// the holding register is still unread is dropped and sets a sticky overrun
// flag.
module uart_rx_param #(
  parameter int unsigned DBIT       = 8,
  parameter int unsigned SB_TICK    = 16,
  parameter int unsigned PARITY_EN  = 0,
  parameter int unsigned PARITY_ODD = 0,
  parameter int unsigned CLK_DIV    = 163,
  parameter int unsigned NB_STATE   = 3
) (
  input  logic            i_clock,
  input  logic            i_reset,
  input  logic            i_rx,
  input  logic            i_rd,
  output logic [DBIT-1:0] o_data,
  output logic            o_valid,
  output logic            o_parity_err,
  output logic            o_frame_err,
  output logic            o_overrun,
  output logic            o_busy
);

  // The sample counter grows past 4 bits when stop bits span more than 16 ticks.
  localparam int unsigned SW = (SB_TICK > 16) ? $clog2(SB_TICK) : 4;
  localparam int unsigned TW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned NW = (DBIT > 1) ? $clog2(DBIT) : 1;

  typedef enum logic [NB_STATE-1:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop
  } state_e;

  state_e          state_q;
  logic [SW-1:0]   s_q;
  logic [NW-1:0]   n_q;
  logic [DBIT-1:0] shreg_q;
  logic            par_err_q;
  logic [TW-1:0]   tick_cnt_q;
  logic            tick;
  logic            rx_meta_q;
  logic            rx_sync_q;
  logic            frame_done;
  logic            par_expect;

  // Two-flop synchronizer; the line idles high, so reset to 1.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
    end else begin
      rx_meta_q <= i_rx;
      rx_sync_q <= rx_meta_q;
    end
  end

  // Free-running oversampling tick generator.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      tick_cnt_q <= '0;
    end else if (tick) begin
      tick_cnt_q <= '0;
    end else begin
      tick_cnt_q <= tick_cnt_q + 1'b1;
    end
  end

  assign tick = (tick_cnt_q == TW'(CLK_DIV - 1));

  // Parity bit value that a correct frame carries for the received payload.
  assign par_expect = (^shreg_q) ^ (PARITY_ODD != 0);

  assign frame_done = (state_q == StStop) && tick && (s_q == SW'(SB_TICK - 1));

  // Receive state machine: start qualification, data shift, parity, stop.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_q   <= StIdle;
      s_q       <= '0;
      n_q       <= '0;
      shreg_q   <= '0;
      par_err_q <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (!rx_sync_q) begin
            state_q <= StStart;
            s_q     <= '0;
          end
        end
        StStart: begin
          if (tick) begin
            if (s_q == SW'(7)) begin
              // Still low mid start bit: a real frame, otherwise a glitch.
              if (!rx_sync_q) begin
                state_q   <= StData;
                s_q       <= '0;
                n_q       <= '0;
                par_err_q <= 1'b0;
              end else begin
                state_q <= StIdle;
              end
            end else begin
              s_q <= s_q + 1'b1;
            end
          end
        end
        StData: begin
          if (tick) begin
            if (s_q == SW'(15)) begin
              s_q     <= '0;
              shreg_q <= {rx_sync_q, shreg_q[DBIT-1:1]};
              if (n_q == NW'(DBIT - 1)) begin
                state_q <= (PARITY_EN != 0) ? StParity : StStop;
              end else begin
                n_q <= n_q + 1'b1;
              end
            end else begin
              s_q <= s_q + 1'b1;
            end
          end
        end
        StParity: begin
          if (tick) begin
            if (s_q == SW'(15)) begin
              s_q       <= '0;
              par_err_q <= (rx_sync_q != par_expect);
              state_q   <= StStop;
            end else begin
              s_q <= s_q + 1'b1;
            end
          end
        end
        StStop: begin
          if (tick) begin
            if (s_q == SW'(SB_TICK - 1)) begin
              s_q     <= '0;
              state_q <= StIdle;
            end else begin
              s_q <= s_q + 1'b1;
            end
          end
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  // Holding register: load on completion, drop on overrun, clear on read.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      o_data       <= '0;
      o_valid      <= 1'b0;
      o_parity_err <= 1'b0;
      o_frame_err  <= 1'b0;
      o_overrun    <= 1'b0;
    end else if (frame_done) begin
      if (!o_valid || i_rd) begin
        o_data       <= shreg_q;
        o_parity_err <= par_err_q;
        o_frame_err  <= ~rx_sync_q;
        o_valid      <= 1'b1;
      end else begin
        o_overrun <= 1'b1;
      end
    end else if (i_rd && o_valid) begin
      o_valid   <= 1'b0;
      o_overrun <= 1'b0;
    end
  end

  assign o_busy = (state_q != StIdle);

endmodule

// File: tb/tb_uart_rx_param.sv
// Directed bench for uart_rx_param: one instance without parity, one with
// even parity, both at CLK_DIV=4 (64 clocks per bit). Expected frames go into
// a scoreboard queue as they are sent and are popped when o_valid shows them.
module tb_uart_rx_param;

  localparam int BitClks = 64;

  typedef struct packed {
    logic [7:0] d;
    logic       pe;
    logic       fe;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx0 = 1'b1;
  logic       rx1 = 1'b1;
  logic       rd0 = 1'b0;
  logic       rd1 = 1'b0;
  logic [7:0] data0, data1;
  logic       v0, v1, pe0, pe1, fe0, fe1, ov0, ov1, busy0, busy1;

  int   errors = 0;
  int   checks = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  uart_rx_param #(
    .DBIT(8), .SB_TICK(16), .PARITY_EN(0), .PARITY_ODD(0), .CLK_DIV(4), .NB_STATE(3)
  ) dut0 (
    .i_clock(clk), .i_reset(rst), .i_rx(rx0), .i_rd(rd0),
    .o_data(data0), .o_valid(v0), .o_parity_err(pe0), .o_frame_err(fe0),
    .o_overrun(ov0), .o_busy(busy0)
  );

  uart_rx_param #(
    .DBIT(8), .SB_TICK(16), .PARITY_EN(1), .PARITY_ODD(0), .CLK_DIV(4), .NB_STATE(3)
  ) dut1 (
    .i_clock(clk), .i_reset(rst), .i_rx(rx1), .i_rd(rd1),
    .o_data(data1), .o_valid(v1), .o_parity_err(pe1), .o_frame_err(fe1),
    .o_overrun(ov1), .o_busy(busy1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic set_rx(input int sel, input logic val);
    if (sel == 0) rx0 = val;
    else rx1 = val;
  endtask

  task automatic drive_bit(input int sel, input logic val, input int clks);
    set_rx(sel, val);
    repeat (clks) @(negedge clk);
  endtask

  // Full frame; a low stop bit is held only 40 clocks so that the line is
  // high again before a follow-on start bit could qualify.
  task automatic send(input int sel, input logic [7:0] d, input bit has_par,
                      input logic par, input bit stop_ok);
    drive_bit(sel, 1'b0, BitClks);
    for (int i = 0; i < 8; i++) drive_bit(sel, d[i], BitClks);
    if (has_par) drive_bit(sel, par, BitClks);
    if (stop_ok) begin
      drive_bit(sel, 1'b1, BitClks);
    end else begin
      drive_bit(sel, 1'b0, 40);
      drive_bit(sel, 1'b1, BitClks - 40);
    end
    drive_bit(sel, 1'b1, 16);
  endtask

  task automatic wait_valid(input int sel);
    int n = 0;
    while (((sel == 0) ? v0 : v1) !== 1'b1 && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk("valid_seen", {31'b0, (sel == 0) ? v0 : v1}, 32'd1);
  endtask

  task automatic check_out(input int sel, input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      chk({tag, "_sb_empty"}, 32'd0, 32'd1);
    end else begin
      e = sb.pop_front();
      chk({tag, "_data"}, {24'b0, (sel == 0) ? data0 : data1}, {24'b0, e.d});
      chk({tag, "_perr"}, {31'b0, (sel == 0) ? pe0 : pe1}, {31'b0, e.pe});
      chk({tag, "_ferr"}, {31'b0, (sel == 0) ? fe0 : fe1}, {31'b0, e.fe});
    end
  endtask

  task automatic pulse_rd(input int sel);
    if (sel == 0) rd0 = 1'b1;
    else rd1 = 1'b1;
    @(negedge clk);
    rd0 = 1'b0;
    rd1 = 1'b0;
  endtask

  initial begin
    // Reset state
    repeat (4) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_valid", {31'b0, v0}, 32'd0);
    chk("rst_data", {24'b0, data0}, 32'd0);
    chk("rst_flags", {29'b0, pe0, fe0, ov0}, 32'd0);
    chk("rst_busy", {30'b0, busy0, busy1}, 32'd0);
    repeat (10) @(negedge clk);

    // Clean 0x55, no parity
    sb.push_back('{d: 8'h55, pe: 1'b0, fe: 1'b0});
    send(0, 8'h55, 1'b0, 1'b0, 1'b1);
    wait_valid(0);
    check_out(0, "f55");
    chk("f55_ovr", {31'b0, ov0}, 32'd0);
    pulse_rd(0);
    chk("f55_rd_valid", {31'b0, v0}, 32'd0);

    // Even parity: 0x01 needs parity bit 1; send 0 first, then 1
    sb.push_back('{d: 8'h01, pe: 1'b1, fe: 1'b0});
    send(1, 8'h01, 1'b1, 1'b0, 1'b1);
    wait_valid(1);
    check_out(1, "par_bad");
    pulse_rd(1);
    sb.push_back('{d: 8'h01, pe: 1'b0, fe: 1'b0});
    send(1, 8'h01, 1'b1, 1'b1, 1'b1);
    wait_valid(1);
    check_out(1, "par_ok");
    pulse_rd(1);
    chk("par_rd_valid", {31'b0, v1}, 32'd0);

    // Framing error on 0x20
    sb.push_back('{d: 8'h20, pe: 1'b0, fe: 1'b1});
    send(0, 8'h20, 1'b0, 1'b0, 1'b0);
    wait_valid(0);
    check_out(0, "ferr");
    repeat (100) @(negedge clk);
    chk("ferr_idle", {31'b0, busy0}, 32'd0);
    pulse_rd(0);

    // Overrun: 0xA5 kept, 0x3C dropped
    sb.push_back('{d: 8'hA5, pe: 1'b0, fe: 1'b0});
    send(0, 8'hA5, 1'b0, 1'b0, 1'b1);
    send(0, 8'h3C, 1'b0, 1'b0, 1'b1);
    wait_valid(0);
    check_out(0, "ovr");
    chk("ovr_flag", {31'b0, ov0}, 32'd1);
    pulse_rd(0);
    chk("ovr_rd", {30'b0, v0, ov0}, 32'd0);

    // 20-clock glitch: START briefly, then back to IDLE with nothing delivered
    drive_bit(0, 1'b0, 10);
    chk("glitch_busy", {31'b0, busy0}, 32'd1);
    drive_bit(0, 1'b0, 10);
    drive_bit(0, 1'b1, 100);
    chk("glitch_idle", {30'b0, busy0, v0}, 32'd0);

    // Reset mid-frame with an unread frame pending
    send(0, 8'h11, 1'b0, 1'b0, 1'b1);
    drive_bit(0, 1'b0, BitClks);
    for (int i = 0; i < 4; i++) drive_bit(0, (i == 0) ? 1'b0 : 1'b1, BitClks);
    chk("mid_busy", {31'b0, busy0}, 32'd1);
    rx0 = 1'b1;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("mid_rst_out", {21'b0, data0, v0, pe0, fe0}, 32'd0);
    chk("mid_rst_st", {30'b0, ov0, busy0}, 32'd0);
    repeat (20) @(negedge clk);
    sb.push_back('{d: 8'h7E, pe: 1'b0, fe: 1'b0});
    send(0, 8'h7E, 1'b0, 1'b0, 1'b1);
    wait_valid(0);
    check_out(0, "f7e");
    chk("sb_drained", sb.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_rx_param.md
UART_RX_PARAM -- requirements
Module: uart_rx_param

Interface
REQ-001 The block SHALL have parameter DBIT, default 8, data bits per frame (5..9).
REQ-002 The block SHALL have parameter SB_TICK, default 16, oversampling ticks for stop bits (16=1, 24=1.5, 32=2).
REQ-003 The block SHALL have parameter PARITY_EN, default 0, which enables the parity bit when 1.
REQ-004 The block SHALL have parameter PARITY_ODD, default 0, selecting odd parity when 1 and even parity when 0.
REQ-005 The block SHALL have parameter CLK_DIV, default 163, i_clock cycles per oversampling tick (16 ticks per bit).
REQ-006 The block SHALL have parameter NB_STATE, default 3, state register width.
REQ-007 The block SHALL use one clock and a synchronous, active-high reset: i_clock and i_reset.
REQ-008 Port i_clock  input  1  system clock, all logic on rising edge.
REQ-009 Port i_reset  input  1  synchronous active-high reset.
REQ-010 Port i_rx  input  1  serial line, idle high, asynchronous to i_clock.
REQ-011 Port i_rd  input  1  consumer read strobe; one-cycle pulse acknowledges o_data.
REQ-012 Port o_data  output  DBIT  last accepted frame payload, LSB received first.
REQ-013 Port o_valid  output  1  o_data holds an unread frame.
REQ-014 Port o_parity_err  output  1  parity mismatch on the frame in o_data (0 when PARITY_EN=0).
REQ-015 Port o_frame_err  output  1  stop bit sampled low on the frame in o_data.
REQ-016 Port o_overrun  output  1  sticky: a frame completed while o_valid=1 and was dropped.
REQ-017 Port o_busy  output  1  high whenever the state machine is not IDLE.

Function
REQ-018 i_rx SHALL pass through a 2-flop synchronizer; all decisions use the synchronized value.
REQ-019 A free-running tick counter SHALL count 0..CLK_DIV-1 and produce a one-cycle tick at CLK_DIV-1, then wrap to 0.
REQ-020 The FSM SHALL have states IDLE, START, DATA, PARITY, STOP, with sample counter s (4 bits) and bit counter n.
REQ-021 In IDLE, a synchronized low on i_rx SHALL move the FSM to START with s=0 on the next clock, independent of tick.
REQ-022 In START, at the tick with s=7, the line SHALL be checked: if low, go to DATA with s=0 and n=0; if high, glitch, return to IDLE with no flags changed.
REQ-023 In DATA, at each tick with s=15, the line SHALL be shifted into bit n (LSB first), s wraps to 0; after bit DBIT-1, go to PARITY if PARITY_EN else STOP.
REQ-024 In PARITY, at the tick with s=15, the sampled bit SHALL be compared with XOR of data bits (inverted when PARITY_ODD); a mismatch sets the pending parity error.
REQ-025 In STOP, at the tick with s=SB_TICK-1 (s widened as needed), the line SHALL be sampled; low sets the pending frame error; then the frame completes and the FSM returns to IDLE.
REQ-026 On completion with o_valid=0, the next clock SHALL load o_data, o_parity_err and o_frame_err, and set o_valid=1.
REQ-027 On completion with o_valid=1 and i_rd=0, the frame SHALL be dropped: o_data and error flags unchanged, o_overrun set.
REQ-028 On completion with o_valid=1 and i_rd=1 in the same cycle, the new frame SHALL be loaded, o_valid stays 1, and o_overrun is not set.
REQ-029 i_rd with o_valid=1 and no completion SHALL clear o_valid and o_overrun on the next clock; o_data and error flags hold.
REQ-030 i_rd with o_valid=0 SHALL have no effect.
REQ-031 A frame with a framing or parity error SHALL still be delivered, flagged.
REQ-032 A low line on return to IDLE SHALL start a new frame immediately (back-to-back frames without idle gap).

Reset
REQ-033 While i_reset=1 at a clock edge: FSM to IDLE, s/n/tick counter to 0, synchronizer flops to 1, o_data=0, o_valid=0, o_parity_err=0, o_frame_err=0, o_overrun=0, o_busy=0.
REQ-034 Reset asserted mid-frame SHALL abort the frame with no output update; reception resumes at the next falling edge after release.

Verification (CLK_DIV=4, one bit = 64 clocks)
REQ-035 DBIT=8, no parity: send 0x55 with 1 stop -> o_valid=1, o_data=0x55, all error flags 0; i_rd pulse -> o_valid=0.
REQ-036 PARITY_EN=1, even: send 0x01 with parity bit 0 -> o_data=0x01, o_parity_err=1; resend with parity bit 1 -> o_parity_err=0.
REQ-037 Send 0x20 with stop bit held low -> o_data=0x20, o_frame_err=1, FSM returns to IDLE.
REQ-038 Send 0xA5 then 0x3C without i_rd -> o_data=0xA5, o_overrun=1; i_rd -> o_valid=0, o_overrun=0.
REQ-039 Low pulse of 20 clocks on i_rx -> START then IDLE, o_valid stays 0; reset at bit 4 of a frame -> all outputs 0, next full frame 0x7E received correctly.
